branch_hazard_ctrl: RTL



---
 rtl/branch_hazard_ctrl_pkg.sv | 45 ++++
 rtl/branch_hazard_ctrl_if.sv | 50 +++++
 rtl/branch_hazard_ctrl_src_sel.sv | 71 +++++++
 rtl/branch_hazard_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage branch hazard controller:
// forwarding selects, write-back selects, branch funct3 codes, FSM states
// and the branch condition decoder.
package branch_hazard_ctrl_pkg;

   // Comparator operand sources
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // MEM-stage write-back select encodings
   localparam logic [1:0] WB_SEL_DMEM = 2'b00;
   localparam logic [1:0] WB_SEL_ALU  = 2'b01;
   localparam logic [1:0] WB_SEL_PC4  = 2'b10;

   // B-type funct3 encodings
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_WAIT    = 2'b01,
      ST_RESOLVE = 2'b10
   } bhc_state_t;

   // Map comparator flags to a taken decision; reserved funct3 never branches.
   function automatic logic branch_cond(input logic [2:0] funct3,
                                        input logic       equal,
                                        input logic       less_than);
      logic taken;
      case (funct3)
         F3_BEQ:           taken = equal;
         F3_BNE:           taken = !equal;
         F3_BLT, F3_BLTU:  taken = less_than;
         F3_BGE, F3_BGEU:  taken = !less_than;
         default:          taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the branch hazard controller.
// master: pipeline/comparator side, slave: the controller.
interface branch_hazard_ctrl_if;
   logic       id_valid;
   logic       id_is_branch;
   logic [2:0] id_funct3;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       ex_valid;
   logic       ex_reg_wen;
   logic       ex_is_load;
   logic [4:0] ex_rd;
   logic       mem_valid;
   logic       mem_reg_wen;
   logic [4:0] mem_rd;
   logic [1:0] mem_wb_sel;
   logic       wb_valid;
   logic       wb_reg_wen;
   logic [4:0] wb_rd;
   logic       equal;
   logic       less_than;
   logic       ext_flush;
   logic       sign_select;
   logic [1:0] forwardBranchA;
   logic [1:0] forwardBranchB;
   logic       stall;
   logic       bubble;
   logic       branch_taken;
   logic       flush_if_id;

   modport master (
      output id_valid, id_is_branch, id_funct3, id_rs1, id_rs2,
             ex_valid, ex_reg_wen, ex_is_load, ex_rd,
             mem_valid, mem_reg_wen, mem_rd, mem_wb_sel,
             wb_valid, wb_reg_wen, wb_rd,
             equal, less_than, ext_flush,
      input  sign_select, forwardBranchA, forwardBranchB,
             stall, bubble, branch_taken, flush_if_id
   );

   modport slave (
      input  id_valid, id_is_branch, id_funct3, id_rs1, id_rs2,
             ex_valid, ex_reg_wen, ex_is_load, ex_rd,
             mem_valid, mem_reg_wen, mem_rd, mem_wb_sel,
             wb_valid, wb_reg_wen, wb_rd,
             equal, less_than, ext_flush,
      output sign_select, forwardBranchA, forwardBranchB,
             stall, bubble, branch_taken, flush_if_id
   );
endinterface

// File: rtl/branch_hazard_ctrl_src_sel.sv
// Per-operand producer matcher: finds the youngest in-flight writer of rs
// and returns how many stall cycles are needed and where the value comes
// from once those stalls have elapsed.
module branch_src_sel
   import branch_hazard_ctrl_pkg::*;
#(
   parameter int STALL_W = 2
) (
   input  logic [4:0]         rs,
   input  logic               ex_valid,
   input  logic               ex_reg_wen,
   input  logic               ex_is_load,
   input  logic [4:0]         ex_rd,
   input  logic               mem_valid,
   input  logic               mem_reg_wen,
   input  logic [4:0]         mem_rd,
   input  logic [1:0]         mem_wb_sel,
   input  logic               wb_valid,
   input  logic               wb_reg_wen,
   input  logic [4:0]         wb_rd,
   output logic [STALL_W-1:0] stall_cnt,
   output logic [1:0]         src
);

   logic ex_hit_s;
   logic mem_hit_s;
   logic wb_hit_s;

   assign ex_hit_s  = ex_valid  && ex_reg_wen  && (ex_rd  != 5'd0) && (ex_rd  == rs);
   assign mem_hit_s = mem_valid && mem_reg_wen && (mem_rd != 5'd0) && (mem_rd == rs);
   assign wb_hit_s  = wb_valid  && wb_reg_wen  && (wb_rd  != 5'd0) && (wb_rd  == rs);

   // Youngest matching producer decides stall count and post-stall source.
   always_comb begin
      stall_cnt = '0;
      src       = FWD_RF;
      if (ex_hit_s) begin
         if (ex_is_load) begin
            // load data reaches WB only after two more cycles
            stall_cnt = STALL_W'(2'd2);
            src       = FWD_WB;
         end else begin
            stall_cnt = STALL_W'(2'd1);
            src       = FWD_MEM;
         end
      end else if (mem_hit_s) begin
         case (mem_wb_sel)
            WB_SEL_ALU: begin
               stall_cnt = '0;
               src       = FWD_MEM;
            end
            WB_SEL_DMEM, WB_SEL_PC4: begin
               // only the ALU result is on the MEM bypass path
               stall_cnt = STALL_W'(2'd1);
               src       = FWD_WB;
            end
            default: begin
               stall_cnt = STALL_W'(2'd1);
               src       = FWD_WB;
            end
         endcase
      end else if (wb_hit_s) begin
         stall_cnt = '0;
         src       = FWD_WB;
      end else begin
         stall_cnt = '0;
         src       = FWD_RF;
      end
   end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard controller: stalls a branch until its operands can
// be bypassed, drives the comparator selects and sign mode, and turns the
// comparator flags into a taken/flush pulse.
// Optional macro BRANCH_HAZARD_PERF_EN adds stall-cycle and taken counters.
module branch_hazard_ctrl
   import branch_hazard_ctrl_pkg::*;
#(
   parameter int STALL_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   branch_hazard_ctrl_if.slave  bus
`ifdef BRANCH_HAZARD_PERF_EN
   ,
   output logic [31:0]          perf_stall_cycles,
   output logic [31:0]          perf_taken
`endif
);

   bhc_state_t         state_r;
   bhc_state_t         state_s;
   logic [STALL_W-1:0] cnt_r;
   logic [STALL_W-1:0] cnt_s;
   logic [1:0]         fwd_a_r;
   logic [1:0]         fwd_a_s;
   logic [1:0]         fwd_b_r;
   logic [1:0]         fwd_b_s;

   logic [STALL_W-1:0] need_a_s;
   logic [STALL_W-1:0] need_b_s;
   logic [STALL_W-1:0] need_s;
   logic [1:0]         src_a_s;
   logic [1:0]         src_b_s;
   logic               is_br_s;
   logic               cond_s;
   logic               stall_s;
   logic               taken_s;
   logic [1:0]         sel_a_s;
   logic [1:0]         sel_b_s;

   branch_src_sel #(.STALL_W(STALL_W)) u_src_a (
      .rs          (bus.id_rs1),
      .ex_valid    (bus.ex_valid),
      .ex_reg_wen  (bus.ex_reg_wen),
      .ex_is_load  (bus.ex_is_load),
      .ex_rd       (bus.ex_rd),
      .mem_valid   (bus.mem_valid),
      .mem_reg_wen (bus.mem_reg_wen),
      .mem_rd      (bus.mem_rd),
      .mem_wb_sel  (bus.mem_wb_sel),
      .wb_valid    (bus.wb_valid),
      .wb_reg_wen  (bus.wb_reg_wen),
      .wb_rd       (bus.wb_rd),
      .stall_cnt   (need_a_s),
      .src         (src_a_s)
   );

   branch_src_sel #(.STALL_W(STALL_W)) u_src_b (
      .rs          (bus.id_rs2),
      .ex_valid    (bus.ex_valid),
      .ex_reg_wen  (bus.ex_reg_wen),
      .ex_is_load  (bus.ex_is_load),
      .ex_rd       (bus.ex_rd),
      .mem_valid   (bus.mem_valid),
      .mem_reg_wen (bus.mem_reg_wen),
      .mem_rd      (bus.mem_rd),
      .mem_wb_sel  (bus.mem_wb_sel),
      .wb_valid    (bus.wb_valid),
      .wb_reg_wen  (bus.wb_reg_wen),
      .wb_rd       (bus.wb_rd),
      .stall_cnt   (need_b_s),
      .src         (src_b_s)
   );

   assign need_s  = (need_a_s > need_b_s) ? need_a_s : need_b_s;
   assign is_br_s = bus.id_valid && bus.id_is_branch;
   assign cond_s  = branch_cond(bus.id_funct3, bus.equal, bus.less_than);

   // Next-state, stall sequencing and comparator select decode.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      fwd_a_s = fwd_a_r;
      fwd_b_s = fwd_b_r;
      stall_s = 1'b0;
      taken_s = 1'b0;
      sel_a_s = FWD_RF;
      sel_b_s = FWD_RF;
      case (state_r)
         ST_IDLE: begin
            if (is_br_s) begin
               if (need_s == '0) begin
                  // operands already reachable: resolve this cycle
                  sel_a_s = src_a_s;
                  sel_b_s = src_b_s;
                  taken_s = cond_s;
               end else begin
                  stall_s = 1'b1;
                  cnt_s   = need_s - STALL_W'(1'b1);
                  fwd_a_s = src_a_s;
                  fwd_b_s = src_b_s;
                  if (need_s > STALL_W'(1'b1)) begin
                     state_s = ST_WAIT;
                  end else begin
                     state_s = ST_RESOLVE;
                  end
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            stall_s = 1'b1;
            if (cnt_r <= STALL_W'(1'b1)) begin
               cnt_s   = '0;
               state_s = ST_RESOLVE;
            end else begin
               cnt_s   = cnt_r - STALL_W'(1'b1);
            end
         end
         ST_RESOLVE: begin
            sel_a_s = fwd_a_r;
            sel_b_s = fwd_b_r;
            taken_s = cond_s;
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = '0;
         end
      endcase
      // an older redirect kills the branch regardless of state
      if (bus.ext_flush) begin
         stall_s = 1'b0;
         taken_s = 1'b0;
         state_s = ST_IDLE;
         cnt_s   = '0;
      end else begin
         stall_s = stall_s;
      end
   end

   // State, stall counter and captured post-stall sources.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         fwd_a_r <= FWD_RF;
         fwd_b_r <= FWD_RF;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         fwd_a_r <= fwd_a_s;
         fwd_b_r <= fwd_b_s;
      end
   end

   // Outputs are forced quiet while reset is held, even mid-stall.
   assign bus.sign_select    = !rst && bus.id_funct3[1];
   assign bus.stall          = !rst && stall_s;
   assign bus.bubble         = !rst && stall_s;
   assign bus.branch_taken   = !rst && taken_s;
   assign bus.flush_if_id    = !rst && taken_s;
   assign bus.forwardBranchA = rst ? FWD_RF : sel_a_s;
   assign bus.forwardBranchB = rst ? FWD_RF : sel_b_s;

`ifdef BRANCH_HAZARD_PERF_EN
   // Free-running wrap-around event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cycles <= 32'd0;
         perf_taken        <= 32'd0;
      end else begin
         perf_stall_cycles <= perf_stall_cycles + (bus.stall        ? 32'd1 : 32'd0);
         perf_taken        <= perf_taken        + (bus.branch_taken ? 32'd1 : 32'd0);
      end
   end
`endif

endmodule
